// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch control front end.
// Optional tick prescaler in stopwatch_ctrl is enabled by STOPWATCH_CTRL_TICK_EN.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

    // 40 ms debounce and 0.1 s tick at 50 MHz
    localparam int unsigned DB_CYCLES_DEF = 2_000_000;
    localparam int unsigned TICK_DIV_DEF  = 5_000_000;

    // Counter width able to hold n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_fsm.sv
// One push-button chain: 2-FF synchronizer, four-state debounce FSM with a
// reload/down-counter, a debounced level and a registered one-cycle press pulse.
module debounce_fsm
    import stopwatch_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int unsigned     CW     = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0]   RELOAD = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    db_state_t     state;
    db_state_t     state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          press_nx;

    // Bring the raw asynchronous button into the clock domain
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Debounce state, stability counter and registered press pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ZERO;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            press <= press_nx;
        end
    end

    // Next-state logic: a level change is accepted only after the synchronized
    // input has stayed at the new value through a full reload countdown
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        press_nx = 1'b0;
        case (state)
            ZERO: begin
                if (sync2) begin
                    state_nx = WAIT1;
                    cnt_nx   = RELOAD;
                end
            end
            WAIT1: begin
                if (!sync2) begin
                    state_nx = ZERO;
                end else if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    state_nx = ONE;
                    press_nx = 1'b1;
                end
            end
            ONE: begin
                if (!sync2) begin
                    state_nx = WAIT0;
                    cnt_nx   = RELOAD;
                end
            end
            WAIT0: begin
                if (sync2) begin
                    state_nx = ONE;
                end else if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    state_nx = ZERO;
                end
            end
            default: begin
                state_nx = ZERO;
            end
        endcase
    end

    assign level = (state == ONE) || (state == WAIT0);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front end: debounces go/clr/up buttons and produces the
// enable, clr and up controls for the counter stage.
// Define STOPWATCH_CTRL_TICK_EN to compile in the 0.1 s tick prescaler;
// otherwise tick is tied low and TICK_DIV is ignored.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned TICK_DIV  = TICK_DIV_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_go,
    input  logic btn_clr,
    input  logic btn_up,
    output logic enable,
    output logic clr,
    output logic up,
    output logic tick
);

    logic [2:0] btn_level;
    logic       go_press;
    logic       clr_press;
    logic       up_press;

    debounce_fsm #(.DB_CYCLES(DB_CYCLES)) u_db_go (
        .clock (clock),
        .reset (reset),
        .btn   (btn_go),
        .level (btn_level[0]),
        .press (go_press)
    );

    debounce_fsm #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clock (clock),
        .reset (reset),
        .btn   (btn_clr),
        .level (btn_level[1]),
        .press (clr_press)
    );

    debounce_fsm #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clock (clock),
        .reset (reset),
        .btn   (btn_up),
        .level (btn_level[2]),
        .press (up_press)
    );

    // Control registers; every decision uses the pre-update enable, clr beats go,
    // and a direction change is allowed when stopped or when clr stops us now
    always_ff @(posedge clock) begin
        if (reset) begin
            enable <= 1'b0;
            clr    <= 1'b0;
            up     <= 1'b0;
        end else begin
            clr <= clr_press;
            if (clr_press) begin
                enable <= 1'b0;
            end else if (go_press) begin
                enable <= ~enable;
            end
            if (up_press && (!enable || clr_press)) begin
                up <= ~up;
            end
        end
    end

`ifdef STOPWATCH_CTRL_TICK_EN
    localparam int unsigned     TW        = cnt_width(TICK_DIV);
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt;

    // Prescaler advances only while running so stop/restart keeps the phase;
    // a clear event restarts the period from zero
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (clr_press) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (enable) begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                tick     <= 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
                tick     <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end
`else
    assign tick = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (DB_CYCLES=4, TICK_DIV=10).
// Tick expectations follow STOPWATCH_CTRL_TICK_EN the same way the design does.
module tb_stopwatch_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned TD = 10;

    logic clock = 1'b0;
    logic reset;
    logic btn_go;
    logic btn_clr;
    logic btn_up;
    logic enable;
    logic clr;
    logic up;
    logic tick;

    int checks   = 0;
    int failures = 0;

    // Expected {enable, clr, up, tick} per clock edge
    logic [3:0] sb[$];

    // Reference model state, button index 0=go 1=clr 2=up
    logic        m_ff1[3];
    logic        m_s[3];
    logic        m_lvl[3];
    logic        m_press[3];
    int unsigned m_run[3];
    logic        m_en;
    logic        m_clr;
    logic        m_up;
    logic        m_tick;
    int unsigned m_tcnt;

    int clr_hi  = 0;
    int tick_hi = 0;

    always #5 clock = ~clock;

    stopwatch_ctrl #(.DB_CYCLES(DB), .TICK_DIV(TD)) dut (
        .clock   (clock),
        .reset   (reset),
        .btn_go  (btn_go),
        .btn_clr (btn_clr),
        .btn_up  (btn_up),
        .enable  (enable),
        .clr     (clr),
        .up      (up),
        .tick    (tick)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model one clock edge: a debounced level flips once DB+1 consecutive
    // synchronized samples disagree with it; controls react to last cycle's press
    task automatic model_edge();
        logic raw[3];
        logic pg, pc, pu, en_old;
        raw[0] = btn_go;
        raw[1] = btn_clr;
        raw[2] = btn_up;
        if (reset) begin
            for (int b = 0; b < 3; b++) begin
                m_ff1[b] = 1'b0; m_s[b] = 1'b0; m_lvl[b] = 1'b0;
                m_press[b] = 1'b0; m_run[b] = 0;
            end
            m_en = 1'b0; m_clr = 1'b0; m_up = 1'b0; m_tick = 1'b0; m_tcnt = 0;
        end else begin
            pg = m_press[0]; pc = m_press[1]; pu = m_press[2]; en_old = m_en;
            m_clr = pc;
            m_en  = pc ? 1'b0 : (pg ? ~en_old : en_old);
            if (pu && (!en_old || pc)) m_up = ~m_up;
`ifdef STOPWATCH_CTRL_TICK_EN
            if (pc) begin
                m_tcnt = 0; m_tick = 1'b0;
            end else if (en_old) begin
                if (m_tcnt == TD - 1) begin
                    m_tcnt = 0; m_tick = 1'b1;
                end else begin
                    m_tcnt++; m_tick = 1'b0;
                end
            end else begin
                m_tick = 1'b0;
            end
`else
            m_tick = 1'b0;
`endif
            for (int b = 0; b < 3; b++) begin
                m_press[b] = 1'b0;
                if (m_s[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB + 1) begin
                        m_lvl[b]   = m_s[b];
                        m_press[b] = m_s[b];
                        m_run[b]   = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_s[b]   = m_ff1[b];
                m_ff1[b] = raw[b];
            end
        end
        sb.push_back({m_en, m_clr, m_up, m_tick});
    endtask

    // One clock: model at the edge, compare 1 time unit later
    task automatic cycle();
        logic [3:0] e;
        @(posedge clock);
        model_edge();
        #1;
        e = sb.pop_front();
        chk("enable", enable, e[3]);
        chk("clr",    clr,    e[2]);
        chk("up",     up,     e[1]);
        chk("tick",   tick,   e[0]);
        if (clr === 1'b1)  clr_hi++;
        if (tick === 1'b1) tick_hi++;
    endtask

    task automatic run(input logic g, input logic c, input logic u, input int n);
        btn_go  = g;
        btn_clr = c;
        btn_up  = u;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int base;
        reset = 1'b1; btn_go = 1'b0; btn_clr = 1'b0; btn_up = 1'b0;
        run(0, 0, 0, 2);
        reset = 1'b0;
        run(0, 0, 0, 3);

        // Reset aborts a debounce in progress
        run(1, 0, 0, 3);
        reset = 1'b1;
        run(0, 0, 0, 2);
        reset = 1'b0;
        run(0, 0, 0, 12);
        chk("reset_abort_enable", enable, 1'b0);

        // Go press latency: enable flips only after the 8th edge
        run(1, 0, 0, 7);
        chk("go_before_latency", enable, 1'b0);
        run(1, 0, 0, 1);
        chk("go_press", enable, 1'b1);
        run(1, 0, 0, 6);
        run(0, 0, 0, 10);
        run(1, 0, 0, 10);
        chk("go_repress", enable, 1'b0);
        run(0, 0, 0, 10);

        // Bounce rejection, then one clean press
        run(1, 0, 0, 1); run(0, 0, 0, 1); run(1, 0, 0, 1); run(0, 0, 0, 1);
        run(0, 0, 0, 10);
        chk("bounce_reject", enable, 1'b0);
        run(1, 0, 0, 10);
        chk("bounce_then_hold", enable, 1'b1);
        run(0, 0, 0, 10);

        // Tick cadence while running, none while stopped, resume on restart
        base = tick_hi;
        run(0, 0, 0, 30);
`ifdef STOPWATCH_CTRL_TICK_EN
        chk_int("tick_count_30", tick_hi - base, 3);
`else
        chk_int("tick_count_30", tick_hi - base, 0);
`endif
        run(1, 0, 0, 10);
        run(0, 0, 0, 5);
        base = tick_hi;
        run(0, 0, 0, 15);
        chk_int("tick_while_stopped", tick_hi - base, 0);
        run(1, 0, 0, 10);
        chk("restart", enable, 1'b1);
        run(0, 0, 0, 25);

        // Clear and go pressed together while running
        base = clr_hi;
        run(1, 1, 0, 10);
        run(0, 0, 0, 10);
        chk_int("clr_pulse_width", clr_hi - base, 1);
        chk("clr_go_enable", enable, 1'b0);

        // Direction lock while running, toggle once stopped
        run(1, 0, 0, 8);
        run(0, 0, 0, 10);
        chk("dir_run", enable, 1'b1);
        run(0, 0, 1, 10);
        run(0, 0, 0, 10);
        chk("dir_locked", up, 1'b0);
        run(1, 0, 0, 8);
        run(0, 0, 0, 10);
        chk("dir_stop", enable, 1'b0);
        run(0, 0, 1, 10);
        run(0, 0, 0, 10);
        chk("dir_toggle", up, 1'b1);

        // Clear and up together while running: direction still toggles
        run(1, 0, 0, 8);
        run(0, 0, 0, 10);
        run(0, 1, 1, 10);
        run(0, 0, 0, 10);
        chk("clr_up_dir", up, 1'b0);
        chk("clr_up_enable", enable, 1'b0);

`ifndef STOPWATCH_CTRL_TICK_EN
        chk_int("tick_never", tick_hi, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
